// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - access-size encodings and default depth for the MEM stage
package mips_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_BYTE = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_e;

  localparam int DEFAULT_MEM_DEPTH = 1024;

endpackage

// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - EX/MEM inputs, stage controls and MEM/WB outputs of the MEM stage
interface mem_wb_stage_if;

  logic        RegWrite_in;
  logic        MemToReg_in;
  logic        Branch_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic [1:0]  MemSize_in;
  logic        MemSigned_in;
  logic [31:0] addResult_in;
  logic        ALUZero_in;
  logic [31:0] ALUResult_in;
  logic [31:0] WriteData_in;
  logic [4:0]  WriteReg_in;
  logic        Stall;
  logic        Flush;

  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic        RegWrite_MEMWB;
  logic        MemToReg_MEMWB;
  logic [31:0] ReadData_MEMWB;
  logic [31:0] ALUResult_MEMWB;
  logic [4:0]  WriteReg_MEMWB;
  logic [31:0] WriteBackData;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        Misaligned;
`endif

  modport master (
    output RegWrite_in, MemToReg_in, Branch_in, MemRead_in, MemWrite_in,
    output MemSize_in, MemSigned_in, addResult_in, ALUZero_in, ALUResult_in,
    output WriteData_in, WriteReg_in, Stall, Flush,
`ifdef MEM_MISALIGN_CHECK_EN
    input  Misaligned,
`endif
    input  PCSrc, BranchTarget, RegWrite_MEMWB, MemToReg_MEMWB, ReadData_MEMWB,
    input  ALUResult_MEMWB, WriteReg_MEMWB, WriteBackData
  );

  modport slave (
    input  RegWrite_in, MemToReg_in, Branch_in, MemRead_in, MemWrite_in,
    input  MemSize_in, MemSigned_in, addResult_in, ALUZero_in, ALUResult_in,
    input  WriteData_in, WriteReg_in, Stall, Flush,
`ifdef MEM_MISALIGN_CHECK_EN
    output Misaligned,
`endif
    output PCSrc, BranchTarget, RegWrite_MEMWB, MemToReg_MEMWB, ReadData_MEMWB,
    output ALUResult_MEMWB, WriteReg_MEMWB, WriteBackData
  );

endinterface

// File: rtl/data_memory.sv
// rtl/data_memory.sv - word array with per-byte-lane synchronous write and asynchronous read
module data_memory #(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 Clk,
  input  logic [3:0]           WE,
  input  logic [ADDR_BITS-1:0] Addr,
  input  logic [31:0]          WData,
  output logic [31:0]          RData
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (WE[lane]) begin
        mem[Addr][8*lane +: 8] <= WData[8*lane +: 8];
      end
    end
  end

  assign RData = mem[Addr];

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage: data-memory access, branch resolve, MEM/WB register (option: MEM_MISALIGN_CHECK_EN)
module mem_wb_stage
  import mips_mem_pkg::*;
#(
  parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
  parameter int ADDR_BITS = $clog2(MEM_DEPTH)
) (
  input  logic         Clk,
  input  logic         Rst,
  mem_wb_stage_if.slave bus
);

  logic [ADDR_BITS-1:0] word_idx;
  logic [1:0]           byte_off;
  mem_size_e            size_eff;
  logic [3:0]           lane_mask;
  logic [3:0]           mem_we;
  logic [31:0]          wdata_lanes;
  logic [31:0]          rdata;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [31:0]          ld_ext;
  logic [31:0]          load_data;
  logic                 misaligned;
  logic                 store_en;
  logic                 reg_write_eff;

  logic                 rw_q;
  logic                 mtr_q;
  logic [31:0]          rd_q;
  logic [31:0]          alu_q;
  logic [4:0]           wr_q;

  // Upper address bits are dropped, so addresses alias modulo MEM_DEPTH*4.
  assign word_idx = bus.ALUResult_in[ADDR_BITS+1:2];
  assign byte_off = bus.ALUResult_in[1:0];

  always_comb begin
    case (bus.MemSize_in)
      SIZE_HALF: size_eff = SIZE_HALF;
      SIZE_BYTE: size_eff = SIZE_BYTE;
      default:   size_eff = SIZE_WORD;
    endcase
  end

  always_comb begin
    lane_mask   = 4'b1111;
    wdata_lanes = bus.WriteData_in;
    case (size_eff)
      SIZE_HALF: begin
        lane_mask   = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{bus.WriteData_in[15:0]}};
      end
      SIZE_BYTE: begin
        lane_mask   = 4'b0001 << byte_off;
        wdata_lanes = {4{bus.WriteData_in[7:0]}};
      end
      default: begin
        lane_mask   = 4'b1111;
        wdata_lanes = bus.WriteData_in;
      end
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = (bus.MemRead_in | bus.MemWrite_in) &
                      (((size_eff == SIZE_WORD) & (byte_off != 2'b00)) |
                       ((size_eff == SIZE_HALF) & byte_off[0]));
  assign bus.Misaligned = misaligned;
`else
  assign misaligned = 1'b0;
`endif

  assign store_en = bus.MemWrite_in & ~bus.Stall & ~bus.Flush & ~Rst & ~misaligned;
  assign mem_we   = store_en ? lane_mask : 4'b0000;

  data_memory #(
    .DEPTH     (MEM_DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_dmem (
    .Clk   (Clk),
    .WE    (mem_we),
    .Addr  (word_idx),
    .WData (wdata_lanes),
    .RData (rdata)
  );

  always_comb begin
    ld_byte = rdata[8*byte_off +: 8];
    ld_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
    case (size_eff)
      SIZE_HALF: ld_ext = {{16{bus.MemSigned_in & ld_half[15]}}, ld_half};
      SIZE_BYTE: ld_ext = {{24{bus.MemSigned_in & ld_byte[7]}}, ld_byte};
      default:   ld_ext = rdata;
    endcase
  end

  assign load_data     = bus.MemRead_in ? ld_ext : 32'h0;
  // A misaligned load still flows down the pipe but must not commit.
  assign reg_write_eff = bus.RegWrite_in & ~(misaligned & bus.MemRead_in);

  always_ff @(posedge Clk) begin
    if (Rst || bus.Flush) begin
      rw_q  <= 1'b0;
      mtr_q <= 1'b0;
      rd_q  <= 32'h0;
      alu_q <= 32'h0;
      wr_q  <= 5'd0;
    end else if (!bus.Stall) begin
      rw_q  <= reg_write_eff;
      mtr_q <= bus.MemToReg_in;
      rd_q  <= load_data;
      alu_q <= bus.ALUResult_in;
      wr_q  <= bus.WriteReg_in;
    end
  end

  assign bus.RegWrite_MEMWB  = rw_q;
  assign bus.MemToReg_MEMWB  = mtr_q;
  assign bus.ReadData_MEMWB  = rd_q;
  assign bus.ALUResult_MEMWB = alu_q;
  assign bus.WriteReg_MEMWB  = wr_q;
  assign bus.WriteBackData   = mtr_q ? rd_q : alu_q;

  assign bus.PCSrc        = bus.Branch_in & bus.ALUZero_in & ~bus.Flush;
  assign bus.BranchTarget = bus.addResult_in;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - randomized bench for mem_wb_stage against a byte-array reference model
module tb_mem_wb_stage;

  localparam int MD    = 1024;
  localparam int BYTES = MD * 4;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  bit   cmp_en  = 1'b0;

  logic [7:0]  mm [BYTES];
  logic        exp_rw, exp_mtr;
  logic [31:0] exp_rd, exp_alu;
  logic [4:0]  exp_wr;

  mem_wb_stage_if bus();

  mem_wb_stage #(.MEM_DEPTH(MD), .ADDR_BITS(10)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference: byte-addressed memory, next MEM/WB contents from the stage rules.
  task automatic model_update();
    logic [31:0] a, ld;
    logic [1:0]  sz;
    logic        mis;
    logic [15:0] v16;
    logic [7:0]  v8;
    int w, h, b;
    a   = bus.ALUResult_in % BYTES;
    sz  = (bus.MemSize_in == 2'b11) ? 2'b00 : bus.MemSize_in;
    b   = int'(a);
    w   = b - (b % 4);
    h   = b - (b % 2);
    mis = (bus.MemRead_in || bus.MemWrite_in) &&
          ((sz == 2'b00 && (b % 4) != 0) || (sz == 2'b01 && (b % 2) != 0));
`ifndef MEM_MISALIGN_CHECK_EN
    mis = 1'b0;
`endif
    v16 = {mm[h+1], mm[h]};
    v8  = mm[b];
    if (sz == 2'b00)      ld = {mm[w+3], mm[w+2], mm[w+1], mm[w]};
    else if (sz == 2'b01) ld = bus.MemSigned_in ? {{16{v16[15]}}, v16} : {16'h0, v16};
    else                  ld = bus.MemSigned_in ? {{24{v8[7]}}, v8} : {24'h0, v8};
    if (!bus.MemRead_in) ld = 32'h0;

    if (rst || bus.Flush) begin
      exp_rw = 0; exp_mtr = 0; exp_rd = 0; exp_alu = 0; exp_wr = 0;
    end else if (!bus.Stall) begin
      exp_rw  = bus.RegWrite_in && !(mis && bus.MemRead_in);
      exp_mtr = bus.MemToReg_in;
      exp_rd  = ld;
      exp_alu = bus.ALUResult_in;
      exp_wr  = bus.WriteReg_in;
    end

    if (bus.MemWrite_in && !bus.Stall && !bus.Flush && !rst && !mis) begin
      if (sz == 2'b00) begin
        for (int i = 0; i < 4; i++) mm[w+i] = bus.WriteData_in[8*i +: 8];
      end else if (sz == 2'b01) begin
        mm[h]   = bus.WriteData_in[7:0];
        mm[h+1] = bus.WriteData_in[15:8];
      end else begin
        mm[b] = bus.WriteData_in[7:0];
      end
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("RegWrite_MEMWB", {31'h0, bus.RegWrite_MEMWB}, {31'h0, exp_rw});
      chk("MemToReg_MEMWB", {31'h0, bus.MemToReg_MEMWB}, {31'h0, exp_mtr});
      chk("ReadData_MEMWB", bus.ReadData_MEMWB, exp_rd);
      chk("ALUResult_MEMWB", bus.ALUResult_MEMWB, exp_alu);
      chk("WriteReg_MEMWB", {27'h0, bus.WriteReg_MEMWB}, {27'h0, exp_wr});
      chk("WriteBackData", bus.WriteBackData, exp_mtr ? exp_rd : exp_alu);
      chk("PCSrc", {31'h0, bus.PCSrc},
          {31'h0, bus.Branch_in & bus.ALUZero_in & ~bus.Flush});
      chk("BranchTarget", bus.BranchTarget, bus.addResult_in);
    end
  end

  task automatic drive(input logic rw, input logic mtr, input logic mr, input logic mw,
                       input logic [1:0] sz, input logic sg, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] wr);
    bus.RegWrite_in  = rw;
    bus.MemToReg_in  = mtr;
    bus.Branch_in    = 1'b0;
    bus.MemRead_in   = mr;
    bus.MemWrite_in  = mw;
    bus.MemSize_in   = sz;
    bus.MemSigned_in = sg;
    bus.addResult_in = 32'h0;
    bus.ALUZero_in   = 1'b0;
    bus.ALUResult_in = alu;
    bus.WriteData_in = wd;
    bus.WriteReg_in  = wr;
    bus.Stall        = 1'b0;
    bus.Flush        = 1'b0;
    rst              = 1'b0;
  endtask

  task automatic st(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz);
    drive(1'b0, 1'b0, 1'b0, 1'b1, sz, 1'b0, addr, data, 5'd0);
  endtask

  task automatic ld(input logic [31:0] addr, input logic [1:0] sz, input logic sg, input logic [4:0] wr);
    drive(1'b1, 1'b1, 1'b1, 1'b0, sz, sg, addr, 32'h0, wr);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    for (int i = 0; i < BYTES; i++) mm[i] = 8'h00;
    exp_rw = 0; exp_mtr = 0; exp_rd = 0; exp_alu = 0; exp_wr = 0;

    ld(32'h40, 2'b00, 1'b0, 5'd7);
    rst = 1'b1;
    step();
    step();
    cmp_en = 1'b1;
    chk("rst_rw", {31'h0, bus.RegWrite_MEMWB}, 32'h0);
    chk("rst_rd", bus.ReadData_MEMWB, 32'h0);
    chk("rst_wr", {27'h0, bus.WriteReg_MEMWB}, 32'h0);

    st(32'h40, 32'hDEADBEEF, 2'b00); step();
    ld(32'h40, 2'b00, 1'b0, 5'd8);   step();
    chk("lw_rd", bus.ReadData_MEMWB, 32'hDEADBEEF);
    chk("lw_wb", bus.WriteBackData, 32'hDEADBEEF);
    chk("model_lw", exp_rd, 32'hDEADBEEF);
    ld(32'h41, 2'b10, 1'b1, 5'd9); step(); chk("lb", bus.ReadData_MEMWB, 32'hFFFFFFBE);
    ld(32'h41, 2'b10, 1'b0, 5'd9); step(); chk("lbu", bus.ReadData_MEMWB, 32'h000000BE);
    ld(32'h42, 2'b01, 1'b1, 5'd9); step(); chk("lh", bus.ReadData_MEMWB, 32'hFFFFDEAD);
    ld(32'h42, 2'b01, 1'b0, 5'd9); step(); chk("lhu", bus.ReadData_MEMWB, 32'h0000DEAD);
    chk("model_lhu", exp_rd, 32'h0000DEAD);

    st(32'h43, 32'h00000011, 2'b10); step();
    ld(32'h40, 2'b00, 1'b0, 5'd2);   step(); chk("sb_lw", bus.ReadData_MEMWB, 32'h11ADBEEF);
    st(32'h40, 32'h00002222, 2'b01); step();
    ld(32'h40, 2'b00, 1'b0, 5'd2);   step(); chk("sh_lw", bus.ReadData_MEMWB, 32'h11AD2222);
    chk("model_sh", exp_rd, 32'h11AD2222);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h1234, 32'h0, 5'd5);
    bus.Branch_in = 1'b1; bus.ALUZero_in = 1'b1; bus.addResult_in = 32'h100;
    #1;
    chk("br_pcsrc", {31'h0, bus.PCSrc}, 32'h1);
    chk("br_target", bus.BranchTarget, 32'h100);
    bus.Flush = 1'b1;
    #1;
    chk("br_flush_pcsrc", {31'h0, bus.PCSrc}, 32'h0);
    step();
    chk("flush_rw", {31'h0, bus.RegWrite_MEMWB}, 32'h0);
    chk("flush_alu", bus.ALUResult_MEMWB, 32'h0);

    st(32'h80, 32'hA5A5A5A5, 2'b00); step();
    ld(32'h40, 2'b00, 1'b0, 5'd3);   step();
    st(32'h80, 32'h00000055, 2'b00); bus.Stall = 1'b1; step();
    chk("stall_rd", bus.ReadData_MEMWB, 32'h11AD2222);
    chk("stall_wr", {27'h0, bus.WriteReg_MEMWB}, 32'd3);
    ld(32'h80, 2'b00, 1'b0, 5'd4); step(); chk("stall_nowrite", bus.ReadData_MEMWB, 32'hA5A5A5A5);

    ld(32'h40, 2'b00, 1'b0, 5'd6); bus.Stall = 1'b1; bus.Flush = 1'b1; step();
    chk("both_rw", {31'h0, bus.RegWrite_MEMWB}, 32'h0);
    chk("both_rd", bus.ReadData_MEMWB, 32'h0);

    ld(32'h40, 2'b00, 1'b0, 5'd6); rst = 1'b1; step();
    chk("rstld_rw", {31'h0, bus.RegWrite_MEMWB}, 32'h0);
    chk("rstld_alu", bus.ALUResult_MEMWB, 32'h0);
    st(32'h80, 32'h77777777, 2'b00); rst = 1'b1; step();
    ld(32'h80, 2'b00, 1'b0, 5'd4); step(); chk("rst_nowrite", bus.ReadData_MEMWB, 32'hA5A5A5A5);

    st(32'h40 + BYTES, 32'h12345678, 2'b00); step();
    ld(32'h40, 2'b00, 1'b0, 5'd1); step(); chk("wrap", bus.ReadData_MEMWB, 32'h12345678);
`ifndef MEM_MISALIGN_CHECK_EN
    ld(32'h42, 2'b00, 1'b0, 5'd1); step(); chk("misalign_word", bus.ReadData_MEMWB, 32'h12345678);
`endif

    for (int i = 0; i < 32; i++) begin
      st(32'(i * 4), $urandom, 2'b00);
      step();
    end

    for (int n = 0; n < 500; n++) begin
      int kind;
      logic [31:0] addr;
      kind = $urandom_range(0, 2);
      addr = 32'($urandom_range(0, 127)) + 32'($urandom_range(0, 3) * BYTES);
      if (kind == 0)
        drive(1'($urandom), 1'b0, 1'b0, 1'b0, 2'($urandom), 1'b0, $urandom, $urandom, 5'($urandom));
      else if (kind == 1)
        drive(1'($urandom), 1'($urandom), 1'b1, 1'b0, 2'($urandom), 1'($urandom), addr, $urandom, 5'($urandom));
      else
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'($urandom), 1'b0, addr, $urandom, 5'($urandom));
      bus.Branch_in    = 1'($urandom);
      bus.ALUZero_in   = 1'($urandom);
      bus.addResult_in = $urandom;
      bus.Stall        = ($urandom_range(0, 99) < 15);
      bus.Flush        = ($urandom_range(0, 99) < 10);
      rst              = ($urandom_range(0, 99) < 3);
      step();
    end

    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    @(negedge clk);
    #1;
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
